// File: rtl/fnd_pkg.sv
// Register map, scan FSM state type and glyph helpers for the FND scan scheduler.
package fnd_pkg;

  // Word offsets, matched against PADDR[4:2]
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_DATA     = 3'd1;
  localparam logic [2:0] REG_SCAN_DIV = 3'd2;
  localparam logic [2:0] REG_BRIGHT   = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;

  typedef enum logic [1:0] {OFF, LIT, DARK} fnd_state_t;

  // Active-high a..g pattern, a = bit 0
  function automatic logic [6:0] seg7(input logic [3:0] hex);
    case (hex)
      4'h0:    seg7 = 7'h3F;
      4'h1:    seg7 = 7'h06;
      4'h2:    seg7 = 7'h5B;
      4'h3:    seg7 = 7'h4F;
      4'h4:    seg7 = 7'h66;
      4'h5:    seg7 = 7'h6D;
      4'h6:    seg7 = 7'h7D;
      4'h7:    seg7 = 7'h07;
      4'h8:    seg7 = 7'h7F;
      4'h9:    seg7 = 7'h6F;
      4'hA:    seg7 = 7'h77;
      4'hB:    seg7 = 7'h7C;
      4'hC:    seg7 = 7'h39;
      4'hD:    seg7 = 7'h5E;
      4'hE:    seg7 = 7'h79;
      default: seg7 = 7'h71;
    endcase
  endfunction

  // Nearest enabled digit after cur (wrapping); cur itself if it is the only one, 0 if none.
  function automatic logic [1:0] next_digit(input logic [1:0] cur, input logic [3:0] mask);
    logic [1:0] cand;
    next_digit = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      cand = cur + k[1:0];
      if (mask[cand]) next_digit = cand;
    end
  endfunction

endpackage

// File: rtl/fnd_slot_timer.sv
// Slot counter for the scan scheduler: counts 0..div_i and flags the end of the lit window and of the slot.
module fnd_slot_timer (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        clear_i,
  input  logic [15:0] div_i,
  input  logic [3:0]  bright_i,
  output logic        slot_end_o,
  output logic        lit_end_o
);
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] slot_len;
  logic [4:0]  bright_p1;
  logic [21:0] prod;
  logic [17:0] on_len;
  logic        on_hit;

  assign slot_len  = {1'b0, div_i} + 17'd1;
  assign bright_p1 = {1'b0, bright_i} + 5'd1;
  assign prod      = 22'(slot_len) * 22'(bright_p1);
  assign on_len    = 18'(prod >> 4);

  // A zero-length window still lights the digit for one cycle rather than the whole slot
  assign on_hit     = (on_len == 18'd0) ? (cnt_q == 16'd0) : ({2'b00, cnt_q} == on_len - 18'd1);
  assign lit_end_o  = on_hit && (on_len < {1'b0, slot_len});
  assign slot_end_o = (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (clear_i || slot_end_o) cnt_d = 16'd0;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) cnt_q <= 16'd0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fnd_scan_scheduler.sv
// APB scan controller for a 4-digit common-anode 7-segment display.
// Holds the register file, the OFF/LIT/DARK scan FSM and the registered pin drivers.
module fnd_scan_scheduler #(
  parameter int SCAN_DEFAULT = 100_000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic [3:0]  fndCom,
  output logic [7:0]  fndFont
);
  import fnd_pkg::*;

  // SCAN_DIV is a 16-bit field, so a wider default keeps only its low 16 bits
  localparam logic [15:0]    DIV_RST    = 16'(SCAN_DEFAULT);
  localparam int             FW         = $clog2(BLINK_FRAMES + 1);
  localparam logic [FW-1:0]  FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic          en_q, blink_en_q;
  logic [3:0]    mask_q, bright_q, bright_sh_q;
  logic [19:0]   data_q, data_sh_q;
  logic [15:0]   div_q, div_sh_q;
  fnd_state_t    state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          blink_q, blink_d;
  logic [3:0]    com_q, com_d;
  logic [7:0]    font_q, font_d;
  logic          wr_en, slot_end, lit_end, timer_clear, frame_tick, unused_bits;
  logic [2:0]    reg_sel;
  logic [31:0]   rdata;
  logic [15:0]   nibs;
  logic [3:0]    dps;

  assign reg_sel     = PADDR[4:2];
  assign wr_en       = PSEL & PENABLE & PWRITE;
  assign PREADY      = PSEL & PENABLE & ~PRESET;
  assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:20]};

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      en_q       <= 1'b0;
      blink_en_q <= 1'b0;
      mask_q     <= 4'hF;
      data_q     <= 20'd0;
      div_q      <= DIV_RST;
      bright_q   <= 4'hF;
    end else if (wr_en) begin
      case (reg_sel)
        REG_CTRL: begin
          en_q       <= PWDATA[0];
          blink_en_q <= PWDATA[1];
          mask_q     <= PWDATA[7:4];
        end
        REG_DATA:     data_q   <= PWDATA[19:0];
        REG_SCAN_DIV: div_q    <= (PWDATA[15:0] < 16'd3) ? 16'd3 : PWDATA[15:0];
        REG_BRIGHT:   bright_q <= PWDATA[3:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (reg_sel)
      REG_CTRL:     rdata = {24'd0, mask_q, 2'b00, blink_en_q, en_q};
      REG_DATA:     rdata = {12'd0, data_q};
      REG_SCAN_DIV: rdata = {16'd0, div_q};
      REG_BRIGHT:   rdata = {28'd0, bright_q};
      REG_STATUS:   rdata = {28'd0, state_q != OFF, blink_q, idx_q};
      default:      rdata = 32'd0;
    endcase
  end
  assign PRDATA = (PSEL && !PWRITE) ? rdata : 32'd0;

  // Shadows follow the registers while idle and are frozen for the duration of every slot
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      data_sh_q   <= 20'd0;
      div_sh_q    <= DIV_RST;
      bright_sh_q <= 4'hF;
    end else if (state_q == OFF || slot_end) begin
      data_sh_q   <= data_q;
      div_sh_q    <= div_q;
      bright_sh_q <= bright_q;
    end
  end

  assign timer_clear = (state_q == OFF) || !en_q;

  fnd_slot_timer u_timer (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .clear_i    (timer_clear),
    .div_i      (div_sh_q),
    .bright_i   (bright_sh_q),
    .slot_end_o (slot_end),
    .lit_end_o  (lit_end)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state_q <= OFF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OFF:  if (en_q) state_d = LIT;
      LIT: begin
        if (!en_q)         state_d = OFF;
        else if (slot_end) state_d = LIT;
        else if (lit_end)  state_d = DARK;
      end
      DARK: begin
        if (!en_q)         state_d = OFF;
        else if (slot_end) state_d = LIT;
      end
      default: state_d = OFF;
    endcase
  end

  assign nibs = data_sh_q[15:0];
  assign dps  = data_sh_q[19:16];

  always_comb begin
    com_d  = 4'hF;
    font_d = 8'hFF;
    if (en_q && state_q == LIT && mask_q[idx_q] && !(blink_en_q && blink_q)) begin
      com_d  = ~(4'b0001 << idx_q);
      font_d = {~dps[idx_q], ~seg7(nibs[{idx_q, 2'b00} +: 4])};
    end
  end

  always_comb begin
    idx_d = idx_q;
    if (!en_q)                 idx_d = 2'd0;
    else if (state_q == OFF)   idx_d = next_digit(2'd3, mask_q);
    else if (slot_end)         idx_d = next_digit(idx_q, mask_q);
  end

  // A frame closes whenever the scan index fails to advance upward
  assign frame_tick = en_q && (state_q != OFF) && slot_end && (idx_d <= idx_q);

  always_comb begin
    frame_d = frame_q;
    blink_d = blink_q;
    if (!en_q) begin
      frame_d = '0;
      blink_d = 1'b0;
    end else if (frame_tick) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      idx_q   <= 2'd0;
      frame_q <= '0;
      blink_q <= 1'b0;
      com_q   <= 4'hF;
      font_q  <= 8'hFF;
    end else begin
      idx_q   <= idx_d;
      frame_q <= frame_d;
      blink_q <= blink_d;
      com_q   <= com_d;
      font_q  <= font_d;
    end
  end

  assign fndCom  = com_q;
  assign fndFont = font_q;

endmodule

// File: tb/tb_fnd_scan_scheduler.sv
// Self-checking bench for fnd_scan_scheduler: APB register reads and per-cycle pin waveforms
// are compared against expectations queued by the stimulus.
`timescale 1ns/1ps
module tb_fnd_scan_scheduler;
  localparam int SCAN_DEF = 1000;
  localparam int BFRAMES  = 2;
  localparam logic [19:0] DATA_A = 20'h1_4321;
  localparam logic [19:0] DATA_B = 20'h0_8765;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PWRITE, PSEL, PENABLE, PREADY;
  logic [3:0]  fndCom;
  logic [7:0]  fndFont;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd_q[$];
  logic [11:0] pin_q[$];
  logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 PCLK = ~PCLK;

  fnd_scan_scheduler #(.SCAN_DEFAULT(SCAN_DEF), .BLINK_FRAMES(BFRAMES)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .fndCom  (fndCom),
    .fndFont (fndFont)
  );

  // Returns on the falling edge just after the committing rising edge.
  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = addr; PWDATA = data; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    $display("apb write addr=%h data=%h", addr, data);
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic rdy);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = addr; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    data = PRDATA;
    rdy  = PREADY;
    PSEL = 1'b0; PENABLE = 1'b0;
    $display("apb read  addr=%h data=%h", addr, data);
  endtask

  // Expected pins for one slot of a digit: lit for the first lit samples, blank afterwards.
  task automatic push_slot(input int idx, input logic [19:0] data, input int lit, input int total, input bit dark);
    logic [3:0]  com;
    logic [15:0] nibs;
    logic [3:0]  dps;
    logic [3:0]  nib;
    com  = ~(4'b0001 << idx);
    nibs = data[15:0];
    dps  = data[19:16];
    nib  = nibs[idx*4 +: 4];
    for (int k = 0; k < total; k++) begin
      if (k < lit && !dark) pin_q.push_back({com, ~dps[idx], ~seg_tab[nib]});
      else                  pin_q.push_back(12'hFFF);
    end
  endtask

  task automatic test_reset();
    logic [31:0] addrs [6];
    logic [31:0] exps [6];
    logic [31:0] rdv, expv;
    logic rdy;
    addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};
    exps  = '{32'hF0, 32'h0, 32'(SCAN_DEF), 32'hF, 32'h0, 32'h0};
    PRESET = 1'b1;
    repeat (3) @(negedge PCLK);
    checks++;
    if ({fndCom, fndFont} !== 12'hFFF) begin
      errors++;
      $display("FAIL reset_pins: com=%b font=%h, expected com=1111 font=ff", fndCom, fndFont);
    end
    PRESET = 1'b0;
    apb_write(32'h14, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) begin
      rd_q.push_back(exps[i]);
      apb_read(addrs[i], rdv, rdy);
      expv = rd_q.pop_front();
      checks++;
      if (rdv !== expv) begin
        errors++;
        $display("FAIL reset_read addr=%h: got %h, expected %h", addrs[i], rdv, expv);
      end
      checks++;
      if (rdy !== 1'b1) begin
        errors++;
        $display("FAIL pready_access: got %b, expected 1", rdy);
      end
    end
  endtask

  task automatic test_basic_scan();
    logic [11:0] expv;
    logic [31:0] rdv, rexp;
    logic rdy;
    apb_write(32'h00, 32'hF0);
    apb_write(32'h08, 32'd9);
    apb_write(32'h04, {12'd0, DATA_A});
    rd_q.push_back({12'd0, DATA_A});
    apb_read(32'h04, rdv, rdy);
    rexp = rd_q.pop_front();
    checks++;
    if (rdv !== rexp) begin
      errors++;
      $display("FAIL data_readback: got %h, expected %h", rdv, rexp);
    end
    pin_q.push_back(12'hFFF);
    for (int s = 0; s < 5; s++) push_slot(s % 4, DATA_A, 10, 10, 1'b0);
    apb_write(32'h00, 32'hF1);
    for (int i = 0; pin_q.size() > 0; i++) begin
      @(negedge PCLK);
      expv = pin_q.pop_front();
      checks++;
      if ({fndCom, fndFont} !== expv) begin
        errors++;
        $display("FAIL basic_scan sample %0d: com=%b font=%h, expected com=%b font=%h",
                 i, fndCom, fndFont, expv[11:8], expv[7:0]);
      end
    end
  endtask

  task automatic test_brightness();
    logic [11:0] expv;
    apb_write(32'h00, 32'hF0);
    apb_write(32'h08, 32'd15);
    apb_write(32'h0C, 32'd3);
    pin_q.push_back(12'hFFF);
    for (int s = 0; s < 3; s++) push_slot(s, DATA_A, 4, 16, 1'b0);
    apb_write(32'h00, 32'hF1);
    for (int i = 0; pin_q.size() > 0; i++) begin
      @(negedge PCLK);
      expv = pin_q.pop_front();
      checks++;
      if ({fndCom, fndFont} !== expv) begin
        errors++;
        $display("FAIL brightness sample %0d: com=%b font=%h, expected com=%b font=%h",
                 i, fndCom, fndFont, expv[11:8], expv[7:0]);
      end
    end
  endtask

  task automatic test_mask_clamp();
    logic [11:0] expv;
    logic [31:0] rdv, rexp;
    logic rdy;
    logic [31:0] wvals [3];
    logic [31:0] rvals [3];
    apb_write(32'h00, 32'hF0);
    apb_write(32'h08, 32'd9);
    apb_write(32'h0C, 32'hF);
    pin_q.push_back(12'hFFF);
    for (int s = 0; s < 4; s++) push_slot((s % 2) * 2, DATA_A, 10, 10, 1'b0);
    apb_write(32'h00, 32'h51);
    for (int i = 0; pin_q.size() > 0; i++) begin
      @(negedge PCLK);
      expv = pin_q.pop_front();
      checks++;
      if ({fndCom, fndFont} !== expv) begin
        errors++;
        $display("FAIL mask_scan sample %0d: com=%b font=%h, expected com=%b font=%h",
                 i, fndCom, fndFont, expv[11:8], expv[7:0]);
      end
    end
    apb_write(32'h00, 32'h50);
    wvals = '{32'd1, 32'd3, 32'd4};
    rvals = '{32'd3, 32'd3, 32'd4};
    for (int i = 0; i < 3; i++) begin
      apb_write(32'h08, wvals[i]);
      rd_q.push_back(rvals[i]);
      apb_read(32'h08, rdv, rdy);
      rexp = rd_q.pop_front();
      checks++;
      if (rdv !== rexp) begin
        errors++;
        $display("FAIL div_clamp wrote %0d: got %0d, expected %0d", wvals[i], rdv, rexp);
      end
    end
  endtask

  task automatic test_tear_free();
    apb_write(32'h00, 32'hF0);
    apb_write(32'h08, 32'd9);
    apb_write(32'h0C, 32'hF);
    apb_write(32'h04, {12'd0, DATA_A});
    pin_q.push_back(12'hFFF);
    push_slot(0, DATA_A, 10, 10, 1'b0);
    push_slot(1, DATA_A, 10, 10, 1'b0);
    push_slot(2, DATA_B, 10, 10, 1'b0);
    push_slot(3, DATA_B, 10, 10, 1'b0);
    push_slot(0, DATA_B, 10, 10, 1'b0);
    apb_write(32'h00, 32'hF1);
    fork
      begin
        logic [11:0] expv;
        for (int i = 0; pin_q.size() > 0; i++) begin
          @(negedge PCLK);
          expv = pin_q.pop_front();
          checks++;
          if ({fndCom, fndFont} !== expv) begin
            errors++;
            $display("FAIL tear_free sample %0d: com=%b font=%h, expected com=%b font=%h",
                     i, fndCom, fndFont, expv[11:8], expv[7:0]);
          end
        end
      end
      begin
        repeat (12) @(negedge PCLK);
        apb_write(32'h04, {12'd0, DATA_B});
      end
    join
  endtask

  task automatic test_blink();
    logic [11:0] expv;
    logic [31:0] rdv, rexp;
    logic rdy;
    apb_write(32'h00, 32'hF0);
    apb_write(32'h08, 32'd3);
    apb_write(32'h04, {12'd0, DATA_A});
    pin_q.push_back(12'hFFF);
    for (int f = 0; f < 3; f++)
      for (int d = 0; d < 4; d++) push_slot(d, DATA_A, 4, 4, f >= 2);
    push_slot(0, DATA_A, 4, 4, 1'b1);
    apb_write(32'h00, 32'hF3);
    for (int i = 0; pin_q.size() > 0; i++) begin
      @(negedge PCLK);
      expv = pin_q.pop_front();
      checks++;
      if ({fndCom, fndFont} !== expv) begin
        errors++;
        $display("FAIL blink sample %0d: com=%b font=%h, expected com=%b font=%h",
                 i, fndCom, fndFont, expv[11:8], expv[7:0]);
      end
    end
    rd_q.push_back(32'hC);
    apb_read(32'h10, rdv, rdy);
    rexp = rd_q.pop_front();
    checks++;
    if ((rdv & 32'hC) !== rexp) begin
      errors++;
      $display("FAIL blink_status: got %h, expected bits[3:2] = %h", rdv, rexp);
    end
    apb_write(32'h00, 32'hF2);
    rd_q.push_back(32'h0);
    apb_read(32'h10, rdv, rdy);
    rexp = rd_q.pop_front();
    checks++;
    if (rdv !== rexp) begin
      errors++;
      $display("FAIL blink_clear_status: got %h, expected %h", rdv, rexp);
    end
  endtask

  task automatic test_disable();
    logic [31:0] rdv, rexp;
    logic rdy;
    apb_write(32'h00, 32'hF0);
    apb_write(32'h08, 32'd9);
    apb_write(32'h00, 32'hF1);
    repeat (15) @(negedge PCLK);
    checks++;
    if (fndCom !== 4'b1101) begin
      errors++;
      $display("FAIL disable_prelit: com=%b, expected 1101", fndCom);
    end
    apb_write(32'h00, 32'hF0);
    @(negedge PCLK);
    checks++;
    if ({fndCom, fndFont} !== 12'hFFF) begin
      errors++;
      $display("FAIL disable_blank: com=%b font=%h, expected com=1111 font=ff", fndCom, fndFont);
    end
    rd_q.push_back(32'h0);
    apb_read(32'h10, rdv, rdy);
    rexp = rd_q.pop_front();
    checks++;
    if (rdv !== rexp) begin
      errors++;
      $display("FAIL disable_status: got %h, expected %h", rdv, rexp);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rdv, rexp;
    logic rdy;
    apb_write(32'h00, 32'hF1);
    repeat (12) @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 32'h0;
    PRESET = 1'b1;
    #1;
    checks++;
    if ({fndCom, fndFont} !== 12'hFFF) begin
      errors++;
      $display("FAIL reset_mid_pins: com=%b font=%h, expected com=1111 font=ff", fndCom, fndFont);
    end
    checks++;
    if (PREADY !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pready: got %b, expected 0", PREADY);
    end
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
    PRESET = 1'b0;
    rd_q.push_back(32'hF0);
    apb_read(32'h00, rdv, rdy);
    rexp = rd_q.pop_front();
    checks++;
    if (rdv !== rexp) begin
      errors++;
      $display("FAIL reset_mid_ctrl: got %h, expected %h", rdv, rexp);
    end
    rd_q.push_back(32'h0);
    apb_read(32'h04, rdv, rdy);
    rexp = rd_q.pop_front();
    checks++;
    if (rdv !== rexp) begin
      errors++;
      $display("FAIL reset_mid_data: got %h, expected %h", rdv, rexp);
    end
  endtask

  initial begin
    PRESET = 1'b1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 32'd0; PWDATA = 32'd0;
    test_reset();
    test_basic_scan();
    test_brightness();
    test_mask_clamp();
    test_tear_free();
    test_blink();
    test_disable();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
